// File: rtl/pong_game_sequencer.sv
// Pong game-phase controller: frame tick from vsync, scores, win detection, speed level.
// frm lands 3 clk after the vs pin edge, frame_tick 4 clk; inputs sampled every cycle, no flow control.
module pong_game_sequencer #(
  parameter int WIN_SCORE      = 7,
  parameter int SERVE_FRAMES   = 60,
  parameter int POINT_FRAMES   = 90,
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 7,
  parameter int VS_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vs,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       paddle_hit,
  output logic       frame_tick,
  output logic       ball_reset,
  output logic [2:0] phase,
  output logic [3:0] score_player,
  output logic [3:0] score_ai,
  output logic [3:0] speed_level,
  output logic       show_over
);

  typedef enum logic [2:0] {
    ATTRACT = 3'd0,
    SERVE   = 3'd1,
    PLAY    = 3'd2,
    POINT   = 3'd3,
    OVER    = 3'd4
  } phase_e;

  localparam logic       ACT_LOW    = (VS_ACTIVE_LOW != 0);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [3:0] HIT_LAST   = 4'(HITS_PER_LEVEL - 1);
  localparam logic [3:0] LVL_MAX    = 4'(MAX_LEVEL);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

  phase_e     state, state_nxt;
  logic [1:0] vs_sy, start_sy, ml_sy, mr_sy, hit_sy;
  logic       vs_d, start_d, hit_d, frm;
  logic       start_e, hit_e, vs_e, miss_l, miss_r;
  logic [7:0] fcnt, fcnt_nxt;
  logic [3:0] hcnt, hcnt_nxt;
  logic [3:0] sp_nxt, sa_nxt, lvl_nxt;
  logic       br_nxt;

  assign start_e = start_sy[1] & ~start_d;
  assign hit_e   = hit_sy[1] & ~hit_d;
  assign miss_l  = ml_sy[1];
  assign miss_r  = mr_sy[1];
  // Edge taken on the raw synchronized level so the all-zero reset state never looks like a pulse.
  assign vs_e    = ACT_LOW ? (vs_d & ~vs_sy[1]) : (~vs_d & vs_sy[1]);

  assign phase     = state;
  assign show_over = (state == OVER);

  always_comb begin
    state_nxt = state;
    sp_nxt    = score_player;
    sa_nxt    = score_ai;
    lvl_nxt   = speed_level;
    hcnt_nxt  = hcnt;
    br_nxt    = 1'b0;
    case (state)
      ATTRACT: if (start_e) begin
        sp_nxt    = 4'd0;
        sa_nxt    = 4'd0;
        lvl_nxt   = 4'd0;
        hcnt_nxt  = 4'd0;
        br_nxt    = 1'b1;
        state_nxt = SERVE;
      end
      SERVE: if (start_e || (frm && fcnt == SERVE_LAST)) state_nxt = PLAY;
      PLAY: begin
        // A miss always wins over a simultaneous paddle hit.
        if (miss_l) begin
          sa_nxt    = score_ai + 4'd1;
          state_nxt = POINT;
        end else if (miss_r) begin
          sp_nxt    = score_player + 4'd1;
          state_nxt = POINT;
        end else if (hit_e) begin
          if (hcnt == HIT_LAST) begin
            hcnt_nxt = 4'd0;
            if (speed_level < LVL_MAX) lvl_nxt = speed_level + 4'd1;
          end else begin
            hcnt_nxt = hcnt + 4'd1;
          end
        end
      end
      POINT: begin
        if (score_player == WIN || score_ai == WIN) begin
          state_nxt = OVER;
        end else if (frm && fcnt == POINT_LAST) begin
          br_nxt    = 1'b1;
          lvl_nxt   = 4'd0;
          hcnt_nxt  = 4'd0;
          state_nxt = SERVE;
        end
      end
      OVER: if (start_e) begin
        sp_nxt    = 4'd0;
        sa_nxt    = 4'd0;
        br_nxt    = 1'b1;
        state_nxt = SERVE;
      end
      default: state_nxt = ATTRACT;
    endcase

    fcnt_nxt = fcnt;
    if (state_nxt != state && (state_nxt == SERVE || state_nxt == POINT)) fcnt_nxt = 8'd0;
    else if (frm) fcnt_nxt = fcnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_sy        <= 2'b00;
      start_sy     <= 2'b00;
      ml_sy        <= 2'b00;
      mr_sy        <= 2'b00;
      hit_sy       <= 2'b00;
      vs_d         <= 1'b0;
      start_d      <= 1'b0;
      hit_d        <= 1'b0;
      frm          <= 1'b0;
      frame_tick   <= 1'b0;
      ball_reset   <= 1'b0;
      state        <= ATTRACT;
      fcnt         <= 8'd0;
      hcnt         <= 4'd0;
      score_player <= 4'd0;
      score_ai     <= 4'd0;
      speed_level  <= 4'd0;
    end else begin
      vs_sy        <= {vs_sy[0], vs};
      start_sy     <= {start_sy[0], start};
      ml_sy        <= {ml_sy[0], miss_left};
      mr_sy        <= {mr_sy[0], miss_right};
      hit_sy       <= {hit_sy[0], paddle_hit};
      vs_d         <= vs_sy[1];
      start_d      <= start_sy[1];
      hit_d        <= hit_sy[1];
      frm          <= vs_e;
      frame_tick   <= frm && (state == PLAY);
      ball_reset   <= br_nxt;
      state        <= state_nxt;
      fcnt         <= fcnt_nxt;
      hcnt         <= hcnt_nxt;
      score_player <= sp_nxt;
      score_ai     <= sa_nxt;
      speed_level  <= lvl_nxt;
    end
  end

endmodule
